// File: rtl/mma_tile_sequencer_if.sv
// Stream bundle between the tile sequencer, the tile fetch logic and the result writeback.
// Carries the cfg, tile and out valid/ready channels.
interface mma_tile_sequencer_if #(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int K     = 2,
    parameter int P     = 8,
    parameter int CNT_W = 8
);
    // Valid/ready rule for every channel: a transfer happens on a rising clk edge
    // where valid && ready; valid never depends combinationally on ready.
    logic                            cfg_valid;
    logic                            cfg_ready;
    logic [CNT_W-1:0]                cfg_k_tiles;
    logic [M-1:0][N-1:0][4*P-1:0]    cfg_c;

    logic                            tile_valid;
    logic                            tile_ready;
    logic [M-1:0][K-1:0][P-1:0]      tile_a;
    logic [K-1:0][N-1:0][P-1:0]      tile_b;

    logic                            out_valid;
    logic                            out_ready;
    logic [M-1:0][N-1:0][4*P-1:0]    out_d;

    modport master (
        output cfg_valid, cfg_k_tiles, cfg_c, tile_valid, tile_a, tile_b, out_ready,
        input  cfg_ready, tile_ready, out_valid, out_d
    );

    modport slave (
        input  cfg_valid, cfg_k_tiles, cfg_c, tile_valid, tile_a, tile_b, out_ready,
        output cfg_ready, tile_ready, out_valid, out_d
    );
endinterface

// File: rtl/mma_tile_sequencer.sv
// Sequences an external combinational MMA array (D = A*B + C) over cfg_k_tiles tile pairs.
// Optional RUN stall counter output enabled by defining MMA_TILE_SEQUENCER_STALL_CNT_EN.
module mma_tile_sequencer #(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int K     = 2,
    parameter int P     = 8,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    mma_tile_sequencer_if.slave          bus,
    output logic [M-1:0][K-1:0][P-1:0]   mma_a,
    output logic [K-1:0][N-1:0][P-1:0]   mma_b,
    output logic [M-1:0][N-1:0][4*P-1:0] mma_c,
    input  logic [M-1:0][N-1:0][4*P-1:0] mma_d,
    output logic [1:0]                   dbg_state,
    output logic                         busy
`ifdef MMA_TILE_SEQUENCER_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [M-1:0][N-1:0][4*P-1:0] acc;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             k_lat;
    logic                         cfg_fire;
    logic                         tile_fire;
    logic                         last_tile;

    assign cfg_fire  = (state == IDLE) && bus.cfg_valid;
    assign tile_fire = (state == RUN) && bus.tile_valid;
    assign last_tile = (cnt == k_lat - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.cfg_valid) state_nxt = (bus.cfg_k_tiles == '0) ? DONE : RUN;
            RUN:  if (bus.tile_valid && last_tile) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only, so no valid follows a ready.
    always_comb begin
        bus.cfg_ready  = (state == IDLE);
        bus.tile_ready = (state == RUN);
        bus.out_valid  = (state == DONE);
        busy           = (state != IDLE);
        dbg_state      = state;
    end

    // The accumulator doubles as the array C operand and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            k_lat <= '0;
        end else if (cfg_fire) begin
            acc   <= bus.cfg_c;
            cnt   <= '0;
            k_lat <= bus.cfg_k_tiles;
        end else if (tile_fire) begin
            acc   <= mma_d;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign mma_a     = bus.tile_a;
    assign mma_b     = bus.tile_b;
    assign mma_c     = acc;
    assign bus.out_d = acc;

`ifdef MMA_TILE_SEQUENCER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || cfg_fire)
            stall_q <= '0;
        else if ((state == RUN) && !bus.tile_valid && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/mma_tile_sequencer.md
Name: mma_tile_sequencer

Overview:
- Sequences the combinational matrix multiply-accumulate array (D = A*B + C) over a long inner dimension.
- Streams cfg_k_tiles pairs of A (MxK) and B (KxN) tiles through the array. The array's C input is fed from an internal accumulator register, which is loaded from D after each accepted tile.
- The array instance lives outside this block and connects through the mma_* ports.
- The block sits between the tile fetch logic (valid/ready streams) and the result writeback (valid/ready).

Parameters:
- M, 2, rows of A/C/D tile
- N, 2, columns of B/C/D tile
- K, 2, inner dimension of one tile pair
- P, 8, element width of A and B; accumulator elements are 4*P
- CNT_W, 8, width of tile count; max job length 2^CNT_W-1 tile pairs

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  job start request
- cfg_ready  out  1  high only in IDLE
- cfg_k_tiles  in  CNT_W  number of tile pairs in the job
- cfg_c  in  signed 4*P x [M][N]  initial accumulator value
- tile_valid  in  1  A/B tile pair available
- tile_ready  out  1  high only in RUN
- tile_a  in  signed P x [M][K]  A tile
- tile_b  in  signed P x [K][N]  B tile
- mma_a  out  signed P x [M][K]  to array A, equals tile_a combinationally
- mma_b  out  signed P x [K][N]  to array B, equals tile_b combinationally
- mma_c  out  signed 4*P x [M][N]  to array C, equals accumulator register
- mma_d  in  signed 4*P x [M][N]  from array D
- out_valid  out  1  result available, high only in DONE
- out_ready  in  1  writeback accepts result
- out_d  out  signed 4*P x [M][N]  equals accumulator register
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; accumulator and tile counter clear to 0.
  - Outputs after reset: cfg_ready=1, tile_ready=0, out_valid=0, busy=0, out_d=0, mma_c=0.
  - Reset mid-job aborts the job immediately. No output is produced and in-flight tiles are discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE, when cfg_valid && cfg_ready:
  - Accumulator <= cfg_c and counter <= 0.
  - If cfg_k_tiles == 0, go to DONE (result = cfg_c unchanged); otherwise go to RUN and latch cfg_k_tiles.
- RUN:
  - tile_ready=1. On each tile_valid && tile_ready edge: accumulator <= mma_d, counter <= counter+1.
  - When the accepted tile is the last one (counter == k_tiles-1), go to DONE.
  - tile_valid low stalls the job with no state change. Throughput is one tile pair per cycle.
- DONE:
  - out_valid=1 and out_d is held stable.
  - On out_valid && out_ready, go to IDLE.
  - out_valid stays high until the handshake completes.
- Latency:
  - out_valid rises on the cycle after the last tile is accepted.
  - For a zero-tile job, out_valid rises on the cycle after the cfg handshake.
- Inputs ignored by state:
  - cfg_valid is ignored outside IDLE.
  - tile_valid is ignored outside RUN; no tile is consumed.
  - out_ready is ignored outside DONE.
- Arithmetic:
  - All accumulation is performed by the external array, modulo 2^(4*P).
  - Wrap-around is silent; there is no saturation or overflow flag.
  - The accumulator register is exactly 4*P bits per element.
- Latched k_tiles is unaffected by cfg_k_tiles changes during RUN.
- Handshake stability:
  - Valid must not depend combinationally on ready.
  - All ready/valid outputs are decoded from registered state only.

Optional Feature:
- Macro: MMA_TILE_SEQUENCER_STALL_CNT_EN.
- With the macro defined:
  - Extra output port stall_cycles (out, 32 bits) counts cycles spent in RUN with tile_valid=0.
  - The counter clears on rst and on each accepted cfg handshake, saturates at 2^32-1, and holds its value in DONE/IDLE.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic job (M=N=K=2, P=8). Stimulus:
  - cfg_c all 1, cfg_k_tiles=1.
  - tile_a=[[1,2],[3,4]], tile_b=[[5,6],[7,8]].
  - Expected: out_d=[[20,23],[44,51]] and out_valid rises 1 cycle after tile accept.
- Multi-tile accumulation:
  - cfg_c=0, k_tiles=3, each tile_a=identity, tile_b=[[1,2],[3,4]], tile_valid held high.
  - Expected: out_d=[[3,6],[9,12]] and exactly 3 tile_ready&&tile_valid cycles.
- Zero-tile job and stalls:
  - k_tiles=0, cfg_c=[[7,-7],[0,5]]: out_d equals cfg_c and tile_ready is never asserted.
  - Separate job: k_tiles=2 with tile_valid gaps of 4 cycles: result is correct and stall_cycles=4 when the macro is enabled.
- Output backpressure:
  - out_ready held low for 5 cycles in DONE.
  - Expected: out_valid stays high, out_d stable, cfg_ready=0 and a new cfg_valid ignored. The job is accepted only after the out handshake.
- Reset mid-job:
  - Assert rst after 1 of 3 tiles.
  - Expected next cycle: IDLE, busy=0, out_d=0, out_valid=0. A fresh job afterwards gives the correct result.
- Wrap-around:
  - cfg_c=2^31-1 (P=8), one tile with a single product of 1 in each element.
  - Expected: out_d = -2^31 in each element.
